// File: rtl/secdec_chan_arb.sv
// Two-port round-robin arbiter in front of one secdec channel, with read tagging, flush/drain and nack counting.
// Optional SECDEC_ARB_ERRINJ_EN: forwards the granted reader's err_mode_in field to sd_err_mode.
module secdec_chan_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    wr_valid,
    input  logic [2*DATA_WIDTH-1:0]       wr_data,
    output logic [1:0]                    wr_ready,
    input  logic [1:0]                    rd_valid,
    output logic [1:0]                    rd_ready,
    input  logic [3:0]                    err_mode_in,
    output logic [1:0]                    resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    input  logic                          flush,
    output logic                          flush_done,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]              nack_cnt,
    output logic                          sd_wr_en,
    output logic [DATA_WIDTH-1:0]         sd_data_in,
    output logic                          sd_rd_en,
    output logic [1:0]                    sd_err_mode,
    input  logic [DATA_WIDTH-1:0]         sd_data_out,
    input  logic                          sd_ack,
    input  logic                          sd_nack
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [LW-1:0]   cnt;
    logic            wr_ptr, rd_ptr;
    logic            drain_rd;
    logic            t0_v, t0_p, t0_d;
    logic            t1_v, t1_p, t1_d;

    // Grants use the pre-update occupancy only, mirroring the channel's own full/empty checks.
    always_comb begin
        state_next = state;
        wr_ready   = '0;
        rd_ready   = '0;
        flush_done = 1'b0;
        drain_rd   = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_next = DRAIN;
                end else begin
                    if (cnt < DEPTH) begin
                        wr_ready[0] = wr_valid[0] && (!wr_ptr || !wr_valid[1]);
                        wr_ready[1] = wr_valid[1] && ( wr_ptr || !wr_valid[0]);
                    end
                    if (cnt != '0) begin
                        rd_ready[0] = rd_valid[0] && (!rd_ptr || !rd_valid[1]);
                        rd_ready[1] = rd_valid[1] && ( rd_ptr || !rd_valid[0]);
                    end
                end
            end
            DRAIN: begin
                drain_rd = (cnt != '0);
                if (cnt == '0 && !t0_v && !t1_v)
                    state_next = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign sd_wr_en   = |wr_ready;
    assign sd_rd_en   = (|rd_ready) || drain_rd;
    assign sd_data_in = wr_ready[1] ? wr_data[DATA_WIDTH +: DATA_WIDTH] :
                        wr_ready[0] ? wr_data[0 +: DATA_WIDTH] : '0;
    assign fill_level = cnt;

`ifdef SECDEC_ARB_ERRINJ_EN
    assign sd_err_mode = rd_ready[1] ? err_mode_in[3:2] :
                         rd_ready[0] ? err_mode_in[1:0] : 2'b00;
`else
    logic unused_err_mode;
    assign unused_err_mode = ^err_mode_in;
    assign sd_err_mode     = 2'b00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            t0_v       <= 1'b0;
            t0_p       <= 1'b0;
            t0_d       <= 1'b0;
            t1_v       <= 1'b0;
            t1_p       <= 1'b0;
            t1_d       <= 1'b0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            nack_cnt   <= '0;
        end else begin
            state <= state_next;
            case ({sd_wr_en, sd_rd_en})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
            if (sd_wr_en)
                wr_ptr <= ~wr_ready[1];
            if (|rd_ready)
                rd_ptr <= ~rd_ready[1];

            // Tag lines up with the channel's response two cycles after the read grant.
            t0_v <= sd_rd_en;
            t0_p <= rd_ready[1];
            t0_d <= drain_rd;
            t1_v <= t0_v;
            t1_p <= t0_p;
            t1_d <= t0_d;

            if (t1_v && !t1_d) begin
                resp_valid <= t1_p ? 2'b10 : 2'b01;
                resp_data  <= sd_data_out;
                resp_err   <= sd_nack;
            end else begin
                resp_valid <= '0;
            end

            if (t1_v && sd_nack && (nack_cnt != '1))
                nack_cnt <= nack_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secdec_chan_arb.sv
// Directed bench for secdec_chan_arb; a behavioural channel (FIFO + 2-cycle response) sits behind the DUT.
module tb_secdec_chan_arb;

    localparam int DW    = 8;
    localparam int CNT_W = 2;
`ifdef SECDEC_ARB_ERRINJ_EN
    localparam bit ERRINJ = 1'b1;
`else
    localparam bit ERRINJ = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     wr_valid, wr_ready, rd_valid, rd_ready;
    logic [2*DW-1:0] wr_data;
    logic [3:0]     err_mode_in;
    logic [1:0]     resp_valid;
    logic [DW-1:0]  resp_data;
    logic           resp_err, flush, flush_done;
    logic [2:0]     fill_level;
    logic [CNT_W-1:0] nack_cnt;
    logic           sd_wr_en, sd_rd_en, sd_ack, sd_nack;
    logic [DW-1:0]  sd_data_in, sd_data_out;
    logic [1:0]     sd_err_mode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    secdec_chan_arb #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .err_mode_in(err_mode_in),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .flush(flush), .flush_done(flush_done), .fill_level(fill_level), .nack_cnt(nack_cnt),
        .sd_wr_en(sd_wr_en), .sd_data_in(sd_data_in), .sd_rd_en(sd_rd_en), .sd_err_mode(sd_err_mode),
        .sd_data_out(sd_data_out), .sd_ack(sd_ack), .sd_nack(sd_nack)
    );

    // Channel model: mode 10 (or force_nack) yields an uncorrectable response.
    logic          force_nack;
    logic [DW-1:0] q[$];
    logic          s1_v = 1'b0, s1_n = 1'b0, s2_v = 1'b0, s2_n = 1'b0;
    logic [DW-1:0] s1_d = '0, s2_d = '0;

    always @(posedge clk) begin
        s1_v <= sd_rd_en;
        s1_n <= (sd_err_mode == 2'b10) || force_nack;
        s1_d <= (sd_rd_en && q.size() != 0) ? q.pop_front() : 8'h00;
        s2_v <= s1_v;
        s2_n <= s1_n;
        s2_d <= s1_d;
        if (rst) q.delete();
        else if (sd_wr_en) q.push_back(sd_data_in);
    end

    assign sd_ack      = s2_v && !s2_n;
    assign sd_nack     = s2_v && s2_n;
    assign sd_data_out = s2_n ? ~s2_d : s2_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single read from port p; response expected on the third edge after the drive point.
    task automatic read_port(input int p, input logic [1:0] em, input logic fn,
                             input logic [DW-1:0] exp_d, input logic exp_e);
        rd_valid    = 2'b01 << p;
        err_mode_in = 4'(em) << (2 * p);
        force_nack  = fn;
        #1;
        chk("rd_grant", rd_ready, 2'b01 << p);
        chk("rd_err_mode", sd_err_mode, ERRINJ ? em : 2'b00);
        tick();
        rd_valid    = '0;
        err_mode_in = '0;
        force_nack  = 1'b0;
        tick();
        chk("resp_early", resp_valid, 2'b00);
        tick();
        chk("resp_valid", resp_valid, 2'b01 << p);
        chk("resp_err", resp_err, exp_e);
        if (!exp_e) chk("resp_data", resp_data, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain_rds, drain_resps;
        rst = 1'b1; wr_valid = '0; wr_data = '0; rd_valid = '0; err_mode_in = '0;
        flush = 1'b0; force_nack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_nack", nack_cnt, 0);
        chk("rst_wr_en", sd_wr_en, 0);

        // 1: single write then read from port 0
        tick();
        wr_valid = 2'b01; wr_data = 16'h00A5;
        #1;
        chk("t1_wr_ready", wr_ready, 2'b01);
        chk("t1_sd_data_in", sd_data_in, 8'hA5);
        tick();
        wr_valid = '0;
        chk("t1_fill", fill_level, 1);
        read_port(0, 2'b00, 1'b0, 8'hA5, 1'b0);
        chk("t1_fill_after", fill_level, 0);

        // 2: both ports write for 4 cycles from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wr_data = {8'(8'h20 + i), 8'(8'h10 + i)};
            #1;
            chk("t2_alt", wr_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        #1;
        chk("t2_full_fill", fill_level, 4);
        chk("t2_full_block", wr_ready, 2'b00);

        // 3: full FIFO, read plus two writes -> only the read is granted
        rd_valid = 2'b10;
        #1;
        chk("t3_rd_grant", rd_ready, 2'b10);
        chk("t3_wr_block", wr_ready, 2'b00);
        tick();
        rd_valid = '0; wr_valid = '0;
        chk("t3_fill", fill_level, 3);
        tick();
        tick();
        chk("t3_resp_valid", resp_valid, 2'b10);
        chk("t3_resp_data", resp_data, 8'h10);

        // 4: corrected read then uncorrectable read on port 1
        tick();
        read_port(1, 2'b01, 1'b0, 8'h21, 1'b0);
        read_port(1, 2'b10, !ERRINJ, 8'h00, 1'b1);
        chk("t4_nack_cnt", nack_cnt, 1);

        // 5: fill to 3, flush, drain with nacking reads (counted, saturating, never returned)
        wr_valid = 2'b01; wr_data = 16'h0031;
        #1; chk("t5_wr_a", wr_ready, 2'b01);
        tick();
        wr_data = 16'h0032;
        #1; chk("t5_wr_b", wr_ready, 2'b01);
        tick();
        wr_valid = '0;
        chk("t5_fill", fill_level, 3);
        flush = 1'b1; wr_valid = 2'b01; force_nack = 1'b1;
        #1; chk("t5_flush_nogrant", wr_ready, 2'b00);
        tick();
        flush = 1'b0; wr_valid = '0;
        drain_rds = 0; drain_resps = 0;
        for (int i = 0; i < 20 && !flush_done; i++) begin
            if (sd_rd_en) drain_rds++;
            if (resp_valid != 2'b00) drain_resps++;
            tick();
        end
        force_nack = 1'b0;
        chk("t5_flush_done", flush_done, 1);
        chk("t5_drain_reads", drain_rds, 3);
        chk("t5_no_resp", drain_resps, 0);
        chk("t5_fill_zero", fill_level, 0);
        chk("t5_nack_sat", nack_cnt, 3);
        tick();
        chk("t5_done_pulse", flush_done, 0);
        wr_valid = 2'b10; wr_data = 16'h4400;
        #1; chk("t5_resume", wr_ready, 2'b10);
        tick();
        wr_valid = '0;
        chk("t5_fill_one", fill_level, 1);

        // 6: reset with a read in flight
        rd_valid = 2'b01;
        #1; chk("t6_rd_grant", rd_ready, 2'b01);
        tick();
        rd_valid = '0; rst = 1'b1;
        #1;
        chk("t6_rst_resp", resp_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_late_drop", resp_valid, 0);
        tick();
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_resp_data", resp_data, 0);
        chk("t6_resp_err", resp_err, 0);
        chk("t6_flush_done", flush_done, 0);
        chk("t6_fill", fill_level, 0);
        chk("t6_nack", nack_cnt, 0);
        chk("t6_wr_ready", wr_ready, 0);
        chk("t6_rd_ready", rd_ready, 0);
        chk("t6_sd_rd_en", sd_rd_en, 0);
        chk("t6_sd_wr_data", {sd_wr_en, sd_data_in}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
